dot_scoreboard: RTL and testbench

Consumer side of the per-dot eaten flags. Each dot instance raises its flag when Pac-Man collides with it. This block scans those flags once per frame, detects newly eaten dots, accumulates a BCD score, and tracks how many dots remain. When the board is empty it signals level clear, then drives the restore pulse that re-arms every dot instance.

---
 rtl/dot_scoreboard.sv | 225 ++++++++++++++++++++++
 tb/tb_dot_scoreboard.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_scoreboard.sv
// dot_scoreboard
//   Scans the per-dot eaten flags once per frame. Each dot that is newly
//   eaten adds points to a saturating BCD score and decrements the count of
//   dots left. When the board is empty the block raises level_clear, waits
//   for level_ack, and then drives dots_restore to re-arm every dot.
//
//   Optional feature macro: POWER_DOT_EN
//     defined   -> adds POWER_MASK / POWER_POINTS parameters and a
//                  power_pulse output; masked dots score POWER_POINTS.
//     undefined -> every dot scores DOT_POINTS.
//
//   Ports:
//     Clk           system clock
//     Reset_n       asynchronous active-low reset
//     eaten         per-dot eaten flags (synchronous to Clk)
//     frame_tick    one-cycle pulse at frame start; starts a scan from IDLE
//     level_ack     game FSM acknowledges level clear (used in CLEAR only)
//     score_bcd     BCD score, digit 0 in bits [3:0]
//     dots_left     number of dots not yet counted as eaten
//     eat_pulse     one-cycle pulse per newly counted dot
//     power_pulse   (POWER_DOT_EN) pulse with eat_pulse for power dots
//     level_clear   high while in CLEAR
//     dots_restore  high while in RESTORE
//     busy          high whenever the FSM is not IDLE
//     state_o       FSM state (0 IDLE, 1 SCAN, 2 CLEAR, 3 RESTORE)
//
//   Handshake: frame_tick and level_ack are sampled as single-cycle pulses
//   and are only acted on in IDLE and CLEAR respectively; in any other state
//   they are dropped, never queued.
module dot_scoreboard #(
  parameter int NUM_DOTS       = 64,
  parameter int DOT_POINTS     = 10,
  parameter int SCORE_DIGITS   = 5,
  parameter int RESTORE_CYCLES = 2
`ifdef POWER_DOT_EN
  ,
  parameter logic [NUM_DOTS-1:0] POWER_MASK = '0,
  parameter int POWER_POINTS = 50
`endif
) (
  input  logic                              Clk,
  input  logic                              Reset_n,
  input  logic [NUM_DOTS-1:0]               eaten,
  input  logic                              frame_tick,
  input  logic                              level_ack,
  output logic [4*SCORE_DIGITS-1:0]         score_bcd,
  output logic [$clog2(NUM_DOTS+1)-1:0]     dots_left,
  output logic                              eat_pulse,
`ifdef POWER_DOT_EN
  output logic                              power_pulse,
`endif
  output logic                              level_clear,
  output logic                              dots_restore,
  output logic                              busy,
  output logic [1:0]                        state_o
);

  localparam int CW = $clog2(NUM_DOTS + 1);
  localparam int IW = $clog2(NUM_DOTS);
  localparam int SW = 4 * SCORE_DIGITS;
  localparam int RW = $clog2(RESTORE_CYCLES + 1);

  localparam logic [3:0] DOT_ONES = 4'(DOT_POINTS % 10);
  localparam logic [3:0] DOT_TENS = 4'(DOT_POINTS / 10);
`ifdef POWER_DOT_EN
  localparam logic [3:0] PWR_ONES = 4'(POWER_POINTS % 10);
  localparam logic [3:0] PWR_TENS = 4'(POWER_POINTS / 10);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    CLEAR   = 2'd2,
    RESTORE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_DOTS-1:0] seen_q, seen_d;
  logic [SW-1:0]       score_q, score_d;
  logic [CW-1:0]       dots_left_q, dots_left_d;
  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic                eat_q, eat_d;
`ifdef POWER_DOT_EN
  logic                pwr_q, pwr_d;
`endif
  logic                hit;
  logic [3:0]          add_ones, add_tens;

  // Ripple-carry BCD add of a two-digit constant; a carry out of the top
  // digit means the true score no longer fits, so it pins at all-9s.
  function automatic logic [SW-1:0] bcd_add(input logic [SW-1:0] a,
                                            input logic [3:0] ones,
                                            input logic [3:0] tens);
    logic [SW-1:0] r;
    logic [4:0]    s;
    logic [3:0]    addend;
    logic          c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      addend = (i == 0) ? ones : ((i == 1) ? tens : 4'd0);
      s = {1'b0, a[4*i +: 4]} + {1'b0, addend} + {4'd0, c};
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    if (SCORE_DIGITS == 1 && tens != 4'd0) c = 1'b1;
    if (c) r = {SCORE_DIGITS{4'd9}};
    return r;
  endfunction

  always_comb begin
`ifdef POWER_DOT_EN
    add_ones = POWER_MASK[idx_q] ? PWR_ONES : DOT_ONES;
    add_tens = POWER_MASK[idx_q] ? PWR_TENS : DOT_TENS;
`else
    add_ones = DOT_ONES;
    add_tens = DOT_TENS;
`endif
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seen_d      = seen_q;
    score_d     = score_q;
    dots_left_d = dots_left_q;
    rcnt_d      = rcnt_q;
    eat_d       = 1'b0;
`ifdef POWER_DOT_EN
    pwr_d       = 1'b0;
`endif
    hit         = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        // seen gates the count, so a flag that stays high is counted once
        // and a flag that falls is simply ignored.
        hit = eaten[idx_q] & ~seen_q[idx_q];
        if (hit) begin
          seen_d[idx_q] = 1'b1;
          score_d       = bcd_add(score_q, add_ones, add_tens);
          dots_left_d   = dots_left_q - CW'(1);
          eat_d         = 1'b1;
`ifdef POWER_DOT_EN
          pwr_d         = POWER_MASK[idx_q];
`endif
        end
        if (idx_q == IW'(NUM_DOTS - 1)) begin
          idx_d   = '0;
          // Decide on the post-update count so the last dot can clear the board.
          state_d = (dots_left_d == '0) ? CLEAR : IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      CLEAR: begin
        if (level_ack) begin
          state_d     = RESTORE;
          seen_d      = '0;
          dots_left_d = CW'(NUM_DOTS);
          rcnt_d      = RW'(RESTORE_CYCLES - 1);
        end
      end
      RESTORE: begin
        if (rcnt_q == '0) state_d = IDLE;
        else              rcnt_d  = rcnt_q - RW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      seen_q      <= '0;
      score_q     <= '0;
      dots_left_q <= CW'(NUM_DOTS);
      rcnt_q      <= '0;
      eat_q       <= 1'b0;
`ifdef POWER_DOT_EN
      pwr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seen_q      <= seen_d;
      score_q     <= score_d;
      dots_left_q <= dots_left_d;
      rcnt_q      <= rcnt_d;
      eat_q       <= eat_d;
`ifdef POWER_DOT_EN
      pwr_q       <= pwr_d;
`endif
    end
  end

  // A hit with nothing left to eat would mean seen[] and dots_left disagree.
  a_no_underflow: assert property (@(posedge Clk) disable iff (!Reset_n)
    !(hit && dots_left_q == '0));

  assign score_bcd    = score_q;
  assign dots_left    = dots_left_q;
  assign eat_pulse    = eat_q;
`ifdef POWER_DOT_EN
  assign power_pulse  = pwr_q;
`endif
  // Decoded straight from the state register so they drop with reset.
  assign level_clear  = (state_q == CLEAR);
  assign dots_restore = (state_q == RESTORE);
  assign busy         = (state_q != IDLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_dot_scoreboard.sv
module tb_dot_scoreboard;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset_n;
  logic [7:0] eaten_a, eaten_s, eaten_p;
  logic       frame_a, frame_s, frame_p;
  logic       ack_a, ack_s, ack_p;

  logic [19:0] score_a;
  logic [7:0]  score_s;
  logic [19:0] score_p;
  logic [3:0]  left_a, left_s, left_p;
  logic        eat_a, eat_s, eat_p;
  logic        clr_a, clr_s, clr_p;
  logic        rst_a, rst_s, rst_p;
  logic        busy_a, busy_s, busy_p;
  logic [1:0]  st_a, st_s, st_p;
  logic        pwr_a, pwr_s, pwr_p;

  int checks = 0;
  int failures = 0;
  int sel = 0;

  logic [19:0] score_m;
  logic [3:0]  left_m;
  logic        eat_m, clr_m, rst_m, busy_m, pwr_m;
  logic [1:0]  st_m;

  // Main board: 8 dots, 10 points, 5 digits, 2-cycle restore.
  dot_scoreboard #(.NUM_DOTS(8), .DOT_POINTS(10), .SCORE_DIGITS(5), .RESTORE_CYCLES(2)) u_a (
    .Clk(Clk), .Reset_n(Reset_n), .eaten(eaten_a), .frame_tick(frame_a), .level_ack(ack_a),
    .score_bcd(score_a), .dots_left(left_a), .eat_pulse(eat_a),
`ifdef POWER_DOT_EN
    .power_pulse(pwr_a),
`endif
    .level_clear(clr_a), .dots_restore(rst_a), .busy(busy_a), .state_o(st_a));

  // Saturation board: 15 points, 2 digits, 1-cycle restore.
  dot_scoreboard #(.NUM_DOTS(8), .DOT_POINTS(15), .SCORE_DIGITS(2), .RESTORE_CYCLES(1)) u_s (
    .Clk(Clk), .Reset_n(Reset_n), .eaten(eaten_s), .frame_tick(frame_s), .level_ack(ack_s),
    .score_bcd(score_s), .dots_left(left_s), .eat_pulse(eat_s),
`ifdef POWER_DOT_EN
    .power_pulse(pwr_s),
`endif
    .level_clear(clr_s), .dots_restore(rst_s), .busy(busy_s), .state_o(st_s));

`ifdef POWER_DOT_EN
  dot_scoreboard #(.NUM_DOTS(8), .DOT_POINTS(10), .SCORE_DIGITS(5), .RESTORE_CYCLES(2),
                   .POWER_MASK(8'h01), .POWER_POINTS(50)) u_p (
    .Clk(Clk), .Reset_n(Reset_n), .eaten(eaten_p), .frame_tick(frame_p), .level_ack(ack_p),
    .score_bcd(score_p), .dots_left(left_p), .eat_pulse(eat_p), .power_pulse(pwr_p),
    .level_clear(clr_p), .dots_restore(rst_p), .busy(busy_p), .state_o(st_p));
`else
  assign {score_p, left_p, eat_p, clr_p, rst_p, busy_p, st_p, pwr_p} = '0;
  assign {pwr_a, pwr_s} = '0;
`endif

  always_comb begin
    case (sel)
      1: begin
        score_m = {12'd0, score_s}; left_m = left_s; eat_m = eat_s; clr_m = clr_s;
        rst_m = rst_s; busy_m = busy_s; st_m = st_s; pwr_m = pwr_s;
      end
      2: begin
        score_m = score_p; left_m = left_p; eat_m = eat_p; clr_m = clr_p;
        rst_m = rst_p; busy_m = busy_p; st_m = st_p; pwr_m = pwr_p;
      end
      default: begin
        score_m = score_a; left_m = left_a; eat_m = eat_a; clr_m = clr_a;
        rst_m = rst_a; busy_m = busy_a; st_m = st_a; pwr_m = pwr_a;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input int w, input logic v);
    case (w)
      1: frame_s = v;
      2: frame_p = v;
      default: frame_a = v;
    endcase
  endtask

  task automatic set_ack(input int w, input logic v);
    case (w)
      1: ack_s = v;
      2: ack_p = v;
      default: ack_a = v;
    endcase
  endtask

  task automatic pulse_frame(input int w);
    @(posedge Clk); #1 set_frame(w, 1'b1);
    @(posedge Clk); #1 set_frame(w, 1'b0);
  endtask

  // Starts a scan and samples a fixed 12-cycle window. Window cycle c=0 is the
  // first cycle with idx 0 in SCAN; the pulse for dot k appears at c=k+1.
  task automatic run_scan(input int w, input logic [7:0] ev, input bit inject,
                          output logic [11:0] em, output logic [11:0] pm,
                          output int busy_cnt);
    sel = w;
    case (w)
      1: eaten_s = ev;
      2: eaten_p = ev;
      default: eaten_a = ev;
    endcase
    em = '0; pm = '0; busy_cnt = 0;
    pulse_frame(w);
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (busy_m) busy_cnt++;
      em[c] = eat_m;
      pm[c] = pwr_m;
      if (inject && c == 3) set_frame(w, 1'b1);
      if (inject && c == 4) set_frame(w, 1'b0);
    end
  endtask

  // Acknowledges a cleared level and counts restore/clear cycles.
  task automatic ack_restore(input int w, input int exp_rcycles);
    int rc;
    int cc;
    rc = 0; cc = 0;
    sel = w;
    @(posedge Clk); #1 set_ack(w, 1'b1);
    @(posedge Clk); #1 set_ack(w, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (c == 0) chk("restore_dots_left", 32'(left_m), 32'd8);
      if (rst_m) rc++;
      if (clr_m) cc++;
    end
    chk("restore_cycles", 32'(rc), 32'(exp_rcycles));
    chk("restore_clear_low", 32'(cc), 32'd0);
    chk("restore_to_idle", 32'(st_m), 32'd0);
  endtask

  logic [11:0] em, pm;
  int bc;
  int cnt;

  initial begin
    Reset_n = 1'b0;
    eaten_a = '0; eaten_s = '0; eaten_p = '0;
    frame_a = 1'b0; frame_s = 1'b0; frame_p = 1'b0;
    ack_a = 1'b0; ack_s = 1'b0; ack_p = 1'b0;

    // Reset state.
    #12;
    chk("rst_score", 32'(score_a), 32'h0);
    chk("rst_left", 32'(left_a), 32'd8);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_eat", 32'(eat_a), 32'd0);
    chk("rst_clear", 32'(clr_a), 32'd0);
    chk("rst_restore", 32'(rst_a), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk);

    // Empty board: 8 busy cycles, no pulses, back to IDLE.
    run_scan(0, 8'h00, 1'b0, em, pm, bc);
    chk("empty_busy", 32'(bc), 32'd8);
    chk("empty_pulses", 32'(em), 32'h0);
    chk("empty_state", 32'(st_a), 32'd0);
    chk("empty_score", 32'(score_a), 32'h0);

    // Dots 0 and 2.
    run_scan(0, 8'b0000_0101, 1'b0, em, pm, bc);
    chk("two_pulses", 32'(em), 32'h00A);
    chk("two_score", 32'(score_a), 32'h00020);
    chk("two_left", 32'(left_a), 32'd6);

    // Same flags again, with a frame_tick injected mid-scan.
    run_scan(0, 8'b0000_0101, 1'b1, em, pm, bc);
    chk("again_pulses", 32'(em), 32'h0);
    chk("again_score", 32'(score_a), 32'h00020);
    chk("inject_busy", 32'(bc), 32'd8);
    chk("inject_state", 32'(st_a), 32'd0);

    // Whole board eaten: six new dots, then CLEAR.
    run_scan(0, 8'hFF, 1'b0, em, pm, bc);
    chk("all_pulses", 32'(em), 32'h1F4);
    chk("all_score", 32'(score_a), 32'h00080);
    chk("all_left", 32'(left_a), 32'd0);
    chk("all_busy", 32'(bc), 32'd12);
    chk("all_clear", 32'(clr_a), 32'd1);

    // frame_tick in CLEAR is dropped; level_clear holds 10 cycles.
    pulse_frame(0);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (clr_a) cnt++;
    end
    chk("clear_hold", 32'(cnt), 32'd10);
    chk("clear_state", 32'(st_a), 32'd2);

    ack_restore(0, 2);
    chk("restore_score", 32'(score_a), 32'h00080);
    eaten_a = '0;

    // 80 + 20 carries across two digits.
    run_scan(0, 8'b0000_0011, 1'b0, em, pm, bc);
    chk("carry_pulses", 32'(em), 32'h006);
    chk("carry_score", 32'(score_a), 32'h00100);
    chk("carry_left", 32'(left_a), 32'd6);

    // Saturation: 15 points into two digits, 90 + 15 pins at 99.
    run_scan(1, 8'hFF, 1'b0, em, pm, bc);
    chk("sat_pulses", 32'(em), 32'h1FE);
    chk("sat_score", 32'(score_s), 32'h99);
    chk("sat_clear", 32'(clr_s), 32'd1);
    ack_restore(1, 1);
    chk("sat_score_kept", 32'(score_s), 32'h99);
    eaten_s = '0;

`ifdef POWER_DOT_EN
    // Power dot at index 0 scores 50, plain dot at index 1 scores 10.
    run_scan(2, 8'h03, 1'b0, em, pm, bc);
    chk("pwr_score", 32'(score_p), 32'h00060);
    chk("pwr_eat_pulses", 32'(em), 32'h006);
    chk("pwr_power_pulses", 32'(pm), 32'h002);
    chk("pwr_left", 32'(left_p), 32'd6);
`endif

    // Reset mid-scan: outputs return to reset values without a clock edge.
    sel = 0;
    eaten_a = 8'h3C;
    pulse_frame(0);
    for (int c = 0; c < 4; c++) @(negedge Clk);
    chk("mid_eat_before", 32'(eat_a), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_eat", 32'(eat_a), 32'd0);
    chk("mid_rst_score", 32'(score_a), 32'h0);
    chk("mid_rst_left", 32'(left_a), 32'd8);
    chk("mid_rst_state", 32'(st_a), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;
    @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
